// File: rtl/output_pkg.sv
// Shared widths, saturation bounds and the FIFO entry type for the output requantizer.
package output_pkg;

  localparam int IO_DATA_WIDTH      = 16;
  localparam int ACCUMULATION_WIDTH = 32;
  localparam int FEATURE_MAP_WIDTH  = 1024;
  localparam int FEATURE_MAP_HEIGHT = 1024;
  localparam int OUTPUT_NB_CHANNELS = 64;

  localparam int X_W  = $clog2(FEATURE_MAP_WIDTH);
  localparam int Y_W  = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CH_W = $clog2(OUTPUT_NB_CHANNELS);

  // One guard bit so adding the rounding offset cannot wrap.
  localparam int SUM_W = ACCUMULATION_WIDTH + 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (IO_DATA_WIDTH - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (IO_DATA_WIDTH - 1)));

  typedef struct packed {
    logic [IO_DATA_WIDTH-1:0] data;
    logic [X_W-1:0]           x;
    logic [Y_W-1:0]           y;
    logic [CH_W-1:0]          ch;
  } out_entry_t;

  localparam int ENTRY_W = $bits(out_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with natural-wrap pointers and a separate occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == (PW + 1)'(DEPTH));

  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/output_requant_fifo.sv
// Requantizes accumulator results (round, shift, saturate) and buffers them for the host.
// Build option: define OUTPUT_RELU_EN to clamp negative results to zero after saturation.
module output_requant_fifo
  import output_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          in_valid,
  input  logic [ACCUMULATION_WIDTH-1:0] in_data,
  input  logic [X_W-1:0]                in_x,
  input  logic [Y_W-1:0]                in_y,
  input  logic [CH_W-1:0]               in_ch,
  input  logic [4:0]                    out_scale,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IO_DATA_WIDTH-1:0]      out_data,
  output logic [X_W-1:0]                out_x,
  output logic [Y_W-1:0]                out_y,
  output logic [CH_W-1:0]               out_ch,
  output logic                          almost_full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  logic signed [SUM_W-1:0]  acc_ext;
  logic signed [SUM_W-1:0]  rnd;
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  shifted;
  logic [IO_DATA_WIDTH-1:0] sat;
  logic [IO_DATA_WIDTH-1:0] req;

  logic       stage_valid;
  out_entry_t stage_entry;
  out_entry_t head_entry;
  out_entry_t out_entry;
  logic       fifo_full;
  logic       fifo_empty;
  logic       drop;

  always_comb begin
    acc_ext = {in_data[ACCUMULATION_WIDTH-1], in_data};
    rnd     = '0;
    if (out_scale != 5'd0) rnd = SUM_W'(1) << (out_scale - 5'd1);
    sum     = acc_ext + rnd;
    shifted = sum >>> out_scale;
    if (shifted > SAT_MAX)      sat = SAT_MAX[IO_DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) sat = SAT_MIN[IO_DATA_WIDTH-1:0];
    else                        sat = shifted[IO_DATA_WIDTH-1:0];
`ifdef OUTPUT_RELU_EN
    req = sat[IO_DATA_WIDTH-1] ? '0 : sat;
`else
    req = sat;
`endif
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      stage_valid <= 1'b0;
      stage_entry <= '0;
    end else begin
      stage_valid      <= in_valid;
      stage_entry.data <= req;
      stage_entry.x    <= in_x;
      stage_entry.y    <= in_y;
      stage_entry.ch   <= in_ch;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (arst_n_in),
    .wr_en   (stage_valid),
    .wr_data (stage_entry),
    .rd_en   (out_ready),
    .rd_data (head_entry),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Storage is not reset, so the head is masked to keep outputs at zero while empty.
  assign out_valid = !fifo_empty;
  assign out_entry = out_valid ? head_entry : '0;
  assign out_data  = out_entry.data;
  assign out_x     = out_entry.x;
  assign out_y     = out_entry.y;
  assign out_ch    = out_entry.ch;

  assign almost_full = (32'(count) >= (FIFO_DEPTH - 2));

  // Full implies non-empty, so a pop is possible exactly when the host is ready.
  assign drop = stage_valid && fifo_full && !out_ready;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)          overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

endmodule
